// File: rtl/cxapbasyncbridge_cdc_capture_data_pkg.sv
// Shared definitions for the async bridge capture/launch pair: FSM encoding
// and the smallest synchroniser depth that is still metastability-safe.
package cxapbasyncbridge_cdc_capture_data_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } cap_state_t;

    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cxapbasyncbridge_cdc_capture_data_sync.sv
// Single-bit multi-flop synchroniser, reset to 0. Depths below the minimum
// are clamped up so a mis-parameterised instance stays safe.
module cxapbasyncbridge_cdc_sync
    import cxapbasyncbridge_cdc_capture_data_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    localparam int DEPTH = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; the last flop is the clean copy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/cxapbasyncbridge_cdc_capture_data.sv
// Destination side of the async bridge data path: synchronises the request
// toggle, captures the source-held word, offers it on valid/ready and returns
// an ack toggle once the word has been taken.
module cxapbasyncbridge_cdc_capture_data
    import cxapbasyncbridge_cdc_capture_data_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_async,
    input  logic [WIDTH-1:0] in_async,
    output logic             ack_async,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             protocol_err
);

    logic             req_sync;
    logic             req_prev_q;
    logic             new_req;
    cap_state_t       state_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ack_q;
    logic             err_q;

    // Only the request toggle crosses through flops; in_async is held stable by the source.
    cxapbasyncbridge_cdc_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (req_async),
        .q_o    (req_sync)
    );

    // Remember the last synchronised request level so any toggle shows up as a one-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_sync;
        end
    end

    assign new_req = req_sync ^ req_prev_q;

    // Capture/hold FSM: a request in HOLD is dropped and flagged, never overwrites the held word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (new_req) begin
                        data_q  <= in_async;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (new_req) begin
                        err_q <= 1'b1;
                    end
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign ack_async    = ack_q;
    assign protocol_err = err_q;

endmodule
